posit_operand_scheduler: RTL and testbench

- Sequences operand decoding in front of the posit multiplier.
- Accepts a posit operand pair (A, B) over a valid/ready handshake and time-shares one combinational field decoder across both operands on successive cycles.
- Registers the decoded fields (sign, regime, exponent, mantissa, zero, NaR) and presents them to the multiplier core over a second valid/ready handshake.
- Flags special values (zero, NaR) so downstream logic can short-circuit.

---
 rtl/posit_sched_pkg.sv | 30 +++
 rtl/posit_field_decode.sv | 57 +++++
 rtl/posit_operand_scheduler.sv | 144 ++++++++++++++
 tb/tb_posit_operand_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_sched_pkg.sv
// Shared types for the posit operand scheduler: FSM state, decoded field bundle
// and the NaR bit pattern.
package posit_sched_pkg;

  localparam int unsigned PositN  = 8;
  localparam int unsigned PositEs = 3;
  localparam int unsigned RegimeW = $clog2(PositN) + 2;
  localparam int unsigned MantW   = PositN - PositEs + 3;

  typedef enum logic [1:0] {
    StIdle,
    StDecA,
    StDecB,
    StOut
  } sched_state_t;

  typedef struct packed {
    logic               sign;
    logic [RegimeW-1:0] regime;
    logic [PositEs-1:0] exp;
    logic [MantW-1:0]   mant;
    logic               zero;
    logic               nar;
  } posit_fields_t;

  function automatic logic [PositN-1:0] nar_word();
    return {1'b1, {(PositN - 1){1'b0}}};
  endfunction

endpackage

// File: rtl/posit_field_decode.sv
// Combinational posit field decoder: sign, signed regime k, exponent and
// left-aligned mantissa with hidden bit; special values only raise their flag.
module posit_field_decode
  import posit_sched_pkg::*;
(
  input  logic [PositN-1:0] word_i,
  output posit_fields_t     fields_o
);

  localparam int unsigned BodyW = PositN - 1;
  localparam int unsigned CntW  = $clog2(PositN) + 1;

  logic [BodyW-1:0]   body;
  logic [BodyW-1:0]   rem;
  logic [CntW-1:0]    run_len;
  logic [RegimeW-1:0] run_ext;
  logic               run_open;
  logic               lead;
  logic               is_zero;
  logic               is_nar;

  assign is_zero = (word_i == '0);
  assign is_nar  = (word_i == nar_word());

  // Negative posits are folded to magnitude before regime detection.
  assign body = word_i[PositN-1] ? (-word_i[BodyW-1:0]) : word_i[BodyW-1:0];
  assign lead = body[BodyW-1];

  always_comb begin
    run_len  = '0;
    run_open = 1'b1;
    for (int i = BodyW - 1; i >= 0; i--) begin
      if (run_open && (body[i] == lead)) begin
        run_len = run_len + CntW'(1);
      end else begin
        run_open = 1'b0;
      end
    end
  end

  // Drop the regime run and its terminator; exponent then fraction sit at the top.
  assign rem     = body << (run_len + CntW'(1));
  assign run_ext = RegimeW'(run_len);

  always_comb begin
    fields_o      = '0;
    fields_o.zero = is_zero;
    fields_o.nar  = is_nar;
    if (!is_zero && !is_nar) begin
      fields_o.sign   = word_i[PositN-1];
      fields_o.regime = lead ? (run_ext - RegimeW'(1)) : (RegimeW'(0) - run_ext);
      fields_o.exp    = rem[BodyW-1 -: PositEs];
      fields_o.mant   = {1'b1, rem[BodyW-PositEs-1:0], 3'b000};
    end
  end

endmodule

// File: rtl/posit_operand_scheduler.sv
// Accepts a posit pair, decodes A then B through one shared decoder, and holds
// the fields for the multiplier. POSIT_SPECIAL_SKIP_EN bypasses decode on zero/NaR.
module posit_operand_scheduler
  import posit_sched_pkg::*;
#(
  parameter int unsigned N  = PositN,
  parameter int unsigned ES = PositEs,
  parameter int unsigned RS = $clog2(N),
  parameter int unsigned CW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            sign_a,
  output logic            sign_b,
  output logic [RS+1:0]   regime_a,
  output logic [RS+1:0]   regime_b,
  output logic [ES-1:0]   exp_a,
  output logic [ES-1:0]   exp_b,
  output logic [N-ES+2:0] mant_a,
  output logic [N-ES+2:0] mant_b,
  output logic            zero_a,
  output logic            zero_b,
  output logic            nar_a,
  output logic            nar_b,
  output logic [CW-1:0]   op_count
);

  sched_state_t  state_q, state_d;
  logic [N-1:0]  opa_q, opa_d;
  logic [N-1:0]  opb_q, opb_d;
  posit_fields_t fa_q, fa_d;
  posit_fields_t fb_q, fb_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  dec_word;
  posit_fields_t dec_fields;

  assign dec_word = (state_q == StDecB) ? opb_q : opa_q;

  posit_field_decode u_decode (
    .word_i   (dec_word),
    .fields_o (dec_fields)
  );

`ifdef POSIT_SPECIAL_SKIP_EN
  logic special_in;
  assign special_in = (in_a == '0) || (in_a == nar_word()) ||
                      (in_b == '0) || (in_b == nar_word());
`endif

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          opa_d   = in_a;
          opb_d   = in_b;
          state_d = StDecA;
`ifdef POSIT_SPECIAL_SKIP_EN
          if (special_in) begin
            fa_d      = '0;
            fb_d      = '0;
            fa_d.zero = (in_a == '0);
            fa_d.nar  = (in_a == nar_word());
            fb_d.zero = (in_b == '0);
            fb_d.nar  = (in_b == nar_word());
            state_d   = StOut;
          end
`endif
        end
      end
      StDecA: begin
        fa_d    = dec_fields;
        state_d = StDecB;
      end
      StDecB: begin
        fb_d    = dec_fields;
        state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Handshake flags are registered copies of the next state.
    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StOut);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      opa_q       <= '0;
      opb_q       <= '0;
      fa_q        <= '0;
      fb_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign op_count  = cnt_q;
  assign sign_a    = fa_q.sign;
  assign sign_b    = fb_q.sign;
  assign regime_a  = fa_q.regime;
  assign regime_b  = fb_q.regime;
  assign exp_a     = fa_q.exp;
  assign exp_b     = fb_q.exp;
  assign mant_a    = fa_q.mant;
  assign mant_b    = fb_q.mant;
  assign zero_a    = fa_q.zero;
  assign zero_b    = fb_q.zero;
  assign nar_a     = fa_q.nar;
  assign nar_b     = fb_q.nar;

endmodule

// File: tb/tb_posit_operand_scheduler.sv
// Randomized + directed bench for posit_operand_scheduler against a behavioural
// posit decoder and a transaction-level timing model.
module tb_posit_operand_scheduler;

  localparam int unsigned TbCw = 5;
`ifdef POSIT_SPECIAL_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [7:0]      in_a = 8'h00;
  logic [7:0]      in_b = 8'h00;
  logic            in_ready, out_valid;
  logic            sign_a, sign_b, zero_a, zero_b, nar_a, nar_b;
  logic [4:0]      regime_a, regime_b;
  logic [2:0]      exp_a, exp_b;
  logic [7:0]      mant_a, mant_b;
  logic [TbCw-1:0] op_count;

  always #5 clk = ~clk;

  posit_operand_scheduler #(
    .CW (TbCw)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .regime_a  (regime_a),
    .regime_b  (regime_b),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .mant_a    (mant_a),
    .mant_b    (mant_b),
    .zero_a    (zero_a),
    .zero_b    (zero_b),
    .nar_a     (nar_a),
    .nar_b     (nar_b),
    .op_count  (op_count)
  );

  typedef struct {
    int sign;
    int regime;
    int expo;
    int mant;
    int zero;
    int nar;
  } ref_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Bit-walking reference decoder over an integer magnitude.
  function automatic ref_t ref_decode(input logic [7:0] x);
    ref_t r;
    int v, i, run, e, m, nb, lead;
    r = '{default: 0};
    if (x == 8'h00) r.zero = 1;
    else if (x == 8'h80) r.nar = 1;
    else begin
      r.sign = int'(x[7]);
      v = int'(x[6:0]);
      if (x[7]) v = (128 - v) % 128;
      lead = (v >> 6) & 1;
      i = 6;
      run = 0;
      while (i >= 0 && ((v >> i) & 1) == lead) begin
        run++;
        i--;
      end
      r.regime = (lead == 1) ? run - 1 : -run;
      i--;
      e = 0;
      for (int b = 0; b < 3; b++) begin
        e = e * 2;
        if (i >= 0) begin
          e += (v >> i) & 1;
          i--;
        end
      end
      m = 1;
      nb = 1;
      while (i >= 0) begin
        m = m * 2 + ((v >> i) & 1);
        i--;
        nb++;
      end
      r.expo = e;
      r.mant = m << (8 - nb);
    end
    return r;
  endfunction

  function automatic ref_t flags_only(input logic [7:0] x);
    ref_t r;
    r = '{default: 0};
    r.zero = (x == 8'h00) ? 1 : 0;
    r.nar  = (x == 8'h80) ? 1 : 0;
    return r;
  endfunction

  function automatic bit is_special(input logic [7:0] x);
    return (x == 8'h00) || (x == 8'h80);
  endfunction

  // Transaction-level model: expected visible state after each clock edge.
  bit   started = 1'b0;
  bit   m_rdy = 1'b0, m_vld = 1'b0, m_busy = 1'b0;
  int   m_age = 0, m_lat = 3, m_cnt = 0;
  ref_t m_fa = '{default: 0}, m_fb = '{default: 0};
  ref_t p_fa = '{default: 0}, p_fb = '{default: 0};

  always @(posedge clk) begin
    started <= 1'b1;
    if (reset) begin
      m_rdy  <= 1'b0;
      m_vld  <= 1'b0;
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_fa   <= '{default: 0};
      m_fb   <= '{default: 0};
    end else if (m_vld) begin
      if (out_ready) begin
        m_vld  <= 1'b0;
        m_busy <= 1'b0;
        m_rdy  <= 1'b1;
        m_cnt  <= (m_cnt + 1) % (1 << TbCw);
      end
    end else if (m_busy) begin
      m_age <= m_age + 1;
      if (m_age + 1 == m_lat - 1) begin
        m_vld <= 1'b1;
        m_fa  <= p_fa;
        m_fb  <= p_fb;
      end
    end else if (in_valid && m_rdy) begin
      m_rdy  <= 1'b0;
      m_busy <= 1'b1;
      m_age  <= 0;
      if (SkipEn && (is_special(in_a) || is_special(in_b))) begin
        m_lat <= 1;
        m_vld <= 1'b1;
        m_fa  <= flags_only(in_a);
        m_fb  <= flags_only(in_b);
      end else begin
        m_lat <= 3;
        p_fa  <= ref_decode(in_a);
        p_fb  <= ref_decode(in_b);
      end
    end else begin
      m_rdy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", in_ready, m_rdy);
      check("out_valid", out_valid, m_vld);
      check("op_count", op_count, m_cnt);
      if (!m_busy || m_vld) begin
        check("sign_a", sign_a, m_fa.sign);
        check("regime_a", $signed(regime_a), m_fa.regime);
        check("exp_a", exp_a, m_fa.expo);
        check("mant_a", mant_a, m_fa.mant);
        check("zero_a", zero_a, m_fa.zero);
        check("nar_a", nar_a, m_fa.nar);
        check("sign_b", sign_b, m_fb.sign);
        check("regime_b", $signed(regime_b), m_fb.regime);
        check("exp_b", exp_b, m_fb.expo);
        check("mant_b", mant_b, m_fb.mant);
        check("zero_b", zero_b, m_fb.zero);
        check("nar_b", nar_b, m_fb.nar);
      end
    end
  end

  function automatic logic [7:0] rnd_word();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  // Called just after a negedge; returns at the negedge where out_valid is seen.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, output int lat);
    int guard;
    guard = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_in_time", int'(guard < 20), 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  ref_t pin;
  int   lat;

  initial begin
    pin = ref_decode(8'h3A);
    check("pin_model_mant_3a", pin.mant, 'hC0);
    check("pin_model_regime_3a", pin.regime, -1);
    pin = ref_decode(8'h60);
    check("pin_model_regime_60", pin.regime, 1);

    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    out_ready = 1'b1;
    send_pair(8'h40, 8'h50, lat);
    check("lat_40_50", lat, 3);
    check("a40_mant", mant_a, 'h80);
    check("a40_exp", exp_a, 0);
    check("b50_exp", exp_b, 4);
    check("b50_mant", mant_b, 'h80);
    @(negedge clk);
    check("count_after_first", op_count, 1);

    send_pair(8'hC0, 8'h60, lat);
    check("ac0_sign", sign_a, 1);
    check("ac0_regime", $signed(regime_a), 0);
    check("ac0_mant", mant_a, 'h80);
    check("b60_regime", $signed(regime_b), 1);
    check("b60_exp", exp_b, 0);
    @(negedge clk);

    send_pair(8'h00, 8'h80, lat);
    check("lat_special", lat, SkipEn ? 1 : 3);
    check("special_zero_a", zero_a, 1);
    check("special_nar_b", nar_b, 1);
    check("special_mant_a", mant_a, 0);
    @(negedge clk);

    out_ready = 1'b0;
    send_pair(8'h3A, 8'hB5, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      check("hold_count", op_count, 3);
      check("hold_mant_a", mant_a, 'hC0);
      check("hold_regime_a", $signed(regime_a), -1);
      check("hold_exp_a", exp_a, 6);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("count_after_hold", op_count, 4);

    in_a = 8'h40;
    in_b = 8'h50;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_count", op_count, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_ready", in_ready, 1);

    for (int i = 0; i < (1 << TbCw); i++) begin
      send_pair(8'h40 + 8'(i), 8'h11 + 8'(i), lat);
      if (i == (1 << TbCw) - 1) check("count_before_wrap", op_count, (1 << TbCw) - 1);
      @(negedge clk);
    end
    check("count_wrapped", op_count, 0);

    for (int c = 0; c < 1500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = rnd_word();
      in_b      = rnd_word();
      reset     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
